// File: rtl/y_window3x3_if.sv
`default_nettype none
// ============================================================================
//  Module   : y_window3x3_if
//  Purpose  : Luma stream in / 3x3 window stream out for y_window3x3.
//             master = stream source and window consumer; slave = the window
//             generator itself.
//  Signals  : y_i, dv_i, hs_i, vs_i, line_end_i     (source -> generator)
//             win_o, win_valid_o, dv_o, hs_o, vs_o,
//             line_end_o, col_o, row_o, overflow_o (generator -> consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface y_window3x3_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 11
);
    logic [7:0]       y_i;
    logic             dv_i;
    logic             hs_i;
    logic             vs_i;
    logic             line_end_i;
    logic [71:0]      win_o;
    logic             win_valid_o;
    logic             dv_o;
    logic             hs_o;
    logic             vs_o;
    logic             line_end_o;
    logic [COL_W-1:0] col_o;
    logic [ROW_W-1:0] row_o;
    logic             overflow_o;

    modport master (
        output y_i, dv_i, hs_i, vs_i, line_end_i,
        input  win_o, win_valid_o, dv_o, hs_o, vs_o, line_end_o,
               col_o, row_o, overflow_o
    );

    modport slave (
        input  y_i, dv_i, hs_i, vs_i, line_end_i,
        output win_o, win_valid_o, dv_o, hs_o, vs_o, line_end_o,
               col_o, row_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/y_window3x3.sv
`default_nettype none
// ============================================================================
//  Module   : y_window3x3
//  Purpose  : Streaming 3x3 luma neighbourhood generator. Two previous lines
//             live in one MAX_WIDTH x 16 line buffer; each valid pixel emits
//             a full 3x3 window two clocks later with sync signals aligned.
//  Ports    : clk   - pixel clock
//             rst_n - asynchronous active-low reset
//             bus   - y_window3x3_if.slave (luma stream in, window stream out)
//  Revision : 1.0 - initial release
// ============================================================================
module y_window3x3 #(
    parameter int MAX_WIDTH = 1024,
    parameter int COL_W     = $clog2(MAX_WIDTH),
    parameter int ROW_W     = 11
) (
    input wire logic     clk,
    input wire logic     rst_n,
    y_window3x3_if.slave bus
);
    localparam logic [COL_W-1:0] c_col_max = COL_W'(MAX_WIDTH - 1);

    // Input-side counters and frame/line state
    logic             r_vs;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_full;      // current line already filled col MAX-1
    logic             r_ovf;       // sticky overflow, input-side timing

    // Stage 0
    logic [7:0]       r_s0_y;
    logic [COL_W-1:0] r_s0_col;
    logic [ROW_W-1:0] r_s0_row;
    logic             r_s0_ovf;
    logic             r_s0_dv, r_s0_hs, r_s0_vs, r_s0_le;

    // Line buffer: {row y-2, row y-1} per column
    logic [15:0]      r_mem [MAX_WIDTH];
    logic [15:0]      r_rd;

    // Stage 1 / outputs
    logic [71:0]      r_win;
    logic             r_win_valid, r_dv_o, r_hs_o, r_vs_o, r_le_o, r_ovf_o;
    logic [COL_W-1:0] r_col_o;
    logic [ROW_W-1:0] r_row_o;

    logic             w_fs;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_full, w_ovf, w_at_max, w_pix_ovf, w_we;
    logic [15:0]      w_wdata;
    logic [23:0]      w_new_col;
    logic [71:0]      w_win_next;

    // A frame start in the same cycle as a pixel makes that pixel (0,0) of
    // the new frame, so the cleared values are used combinationally.
    assign w_fs      = bus.vs_i & ~r_vs;
    assign w_col     = w_fs ? '0 : r_col;
    assign w_row     = w_fs ? '0 : r_row;
    assign w_full    = w_fs ? 1'b0 : r_full;
    assign w_ovf     = w_fs ? 1'b0 : r_ovf;
    assign w_at_max  = (w_col == c_col_max);
    assign w_pix_ovf = bus.dv_i & w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs   <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_vs  <= bus.vs_i;
            r_ovf <= w_ovf | w_pix_ovf;
            if (bus.dv_i && bus.line_end_i) begin
                r_col  <= '0;
                r_row  <= (&w_row) ? w_row : w_row + ROW_W'(1);
                r_full <= 1'b0;
            end else if (bus.dv_i) begin
                r_col  <= w_at_max ? w_col : w_col + COL_W'(1);
                r_row  <= w_row;
                r_full <= w_full | w_at_max;
            end else begin
                r_col  <= w_col;
                r_row  <= w_row;
                r_full <= w_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_y   <= '0;
            r_s0_col <= '0;
            r_s0_row <= '0;
            r_s0_ovf <= 1'b0;
            r_s0_dv  <= 1'b0;
            r_s0_hs  <= 1'b0;
            r_s0_vs  <= 1'b0;
            r_s0_le  <= 1'b0;
        end else begin
            r_s0_dv <= bus.dv_i;
            r_s0_hs <= bus.hs_i;
            r_s0_vs <= bus.vs_i;
            r_s0_le <= bus.line_end_i;
            if (bus.dv_i) begin
                r_s0_y   <= bus.y_i;
                r_s0_col <= w_col;
                r_s0_row <= w_row;
                r_s0_ovf <= w_pix_ovf;
            end
        end
    end

    // The write-back needs the row y-1 byte that the read returns, so it
    // lands one cycle after the read. When the next pixel reads the column
    // being written (single-pixel lines), the write data is forwarded.
    assign w_we    = r_s0_dv & ~r_s0_ovf;
    assign w_wdata = {r_rd[7:0], r_s0_y};

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_s0_col] <= w_wdata;
        end
        if (bus.dv_i) begin
            r_rd <= (w_we && (r_s0_col == w_col)) ? w_wdata : r_mem[w_col];
        end
    end

    // Newest column enters at c=2 of every row; older columns slide to c=0.
    assign w_new_col = {r_s0_y, r_rd[7:0], r_rd[15:8]};

    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_next[8*(3*r)   +: 8] = r_win[8*(3*r+1) +: 8];
            w_win_next[8*(3*r+1) +: 8] = r_win[8*(3*r+2) +: 8];
            w_win_next[8*(3*r+2) +: 8] = w_new_col[8*r +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_dv_o      <= 1'b0;
            r_hs_o      <= 1'b0;
            r_vs_o      <= 1'b0;
            r_le_o      <= 1'b0;
            r_ovf_o     <= 1'b0;
            r_col_o     <= '0;
            r_row_o     <= '0;
        end else begin
            r_dv_o  <= r_s0_dv;
            r_hs_o  <= r_s0_hs;
            r_vs_o  <= r_s0_vs;
            r_le_o  <= r_s0_le;
            r_ovf_o <= r_ovf;
            if (r_s0_dv) begin
                r_win       <= w_win_next;
                r_col_o     <= r_s0_col;
                r_row_o     <= r_s0_row;
                r_win_valid <= (r_s0_col >= COL_W'(2)) &
                               (r_s0_row >= ROW_W'(2)) & ~r_s0_ovf;
            end else begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign bus.win_o       = r_win;
    assign bus.win_valid_o = r_win_valid;
    assign bus.dv_o        = r_dv_o;
    assign bus.hs_o        = r_hs_o;
    assign bus.vs_o        = r_vs_o;
    assign bus.line_end_o  = r_le_o;
    assign bus.col_o       = r_col_o;
    assign bus.row_o       = r_row_o;
    assign bus.overflow_o  = r_ovf_o;
endmodule
`default_nettype wire

// File: tb/tb_y_window3x3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_window3x3
//  Purpose  : Directed self-checking bench for y_window3x3 (MAX_WIDTH=16):
//             ramp frames (continuous and gapped), overflow, mid-frame
//             reset, short lines and frame start coincident with a pixel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_y_window3x3;
    localparam int MAXW = 16;
    localparam int COLW = 4;
    localparam int ROWW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    y_window3x3_if #(.COL_W(COLW), .ROW_W(ROWW)) bus ();

    y_window3x3 #(.MAX_WIDTH(MAXW), .COL_W(COLW), .ROW_W(ROWW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    // Expectations for the tick whose outputs appear on the next tick
    logic       p_dv, p_hs, p_vs, p_le, p_valid, p_ovf, p_ramp;
    logic [7:0] p_y;
    int         p_x, p_row;
    logic       h_ok;
    int         h_x, h_y;
    logic       e_ovf;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] ramp_win(input int x, input int y);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = 8'(16*(y-2+r) + (x-2+c));
        return w;
    endfunction

    task automatic clear_expect();
        p_dv = 0; p_hs = 0; p_vs = 0; p_le = 0; p_valid = 0; p_ovf = 0;
        p_ramp = 0; p_y = '0; p_x = 0; p_row = 0; h_ok = 0; e_ovf = 0;
    endtask

    task automatic tick(input logic [7:0] y, input logic dv, input logic hs,
                        input logic vs, input logic le, input int ex,
                        input int erow, input logic evalid, input logic ramp);
        bus.y_i = y; bus.dv_i = dv; bus.hs_i = hs; bus.vs_i = vs; bus.line_end_i = le;
        @(posedge clk);
        #1;
        chk("dv_o",        72'(bus.dv_o),        72'(p_dv));
        chk("hs_o",        72'(bus.hs_o),        72'(p_hs));
        chk("vs_o",        72'(bus.vs_o),        72'(p_vs));
        chk("line_end_o",  72'(bus.line_end_o),  72'(p_le));
        chk("overflow_o",  72'(bus.overflow_o),  72'(p_ovf));
        chk("win_valid_o", 72'(bus.win_valid_o), 72'(p_dv & p_valid));
        if (bus.win_valid_o) n_valid++;
        if (p_dv) begin
            chk("win_newest", 72'(bus.win_o[71:64]), 72'(p_y));
            chk("col_o",      72'(bus.col_o),        72'(p_x));
            chk("row_o",      72'(bus.row_o),        72'(p_row));
            if (p_valid && p_ramp)
                chk("win_ramp", bus.win_o, ramp_win(p_x, p_row));
            if (p_valid && p_ramp && p_x == 4 && p_row == 2)
                chk("win_4_2", bus.win_o, 72'h24_23_22_14_13_12_04_03_02);
            h_ok = p_valid && p_ramp;
            h_x  = p_x;
            h_y  = p_row;
        end else if (h_ok) begin
            chk("win_hold", bus.win_o, ramp_win(h_x, h_y));
        end
        p_dv = dv; p_hs = hs; p_vs = vs; p_le = le; p_y = y;
        p_x = ex; p_row = erow; p_valid = evalid; p_ramp = ramp; p_ovf = e_ovf;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic vs_pulse();
        e_ovf = 0;
        tick(8'h00, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);
    endtask

    // One line of pixels with an hsync tick after it; erow is the row the
    // generator is expected to report for this line.
    task automatic send_line(input int erow, input int width, input int gap,
                             input logic ramp, input logic vs_first);
        for (int x = 0; x < width; x++) begin
            logic [7:0] y;
            logic vs, ovp;
            y   = ramp ? 8'(16*erow + x) : 8'(x*37 + erow*11 + 3);
            vs  = vs_first && (x == 0);
            ovp = (x >= MAXW);
            if (vs)  e_ovf = 0;
            if (ovp) e_ovf = 1;
            tick(y, 1, 0, vs, (x == width-1), (x < MAXW) ? x : MAXW-1, erow,
                 (x >= 2) && (erow >= 2) && !ovp, ramp);
            idle(gap);
        end
        tick(8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ramp_frame(input int gap);
        n_valid = 0;
        vs_pulse();
        for (int r = 0; r < 4; r++) send_line(r, 8, gap, 1, 0);
        idle(2);
        chk("valid_count_ramp", 72'(n_valid), 72'd12);
    endtask

    initial begin
        clear_expect();
        bus.y_i = '0; bus.dv_i = 0; bus.hs_i = 0; bus.vs_i = 0; bus.line_end_i = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win",       bus.win_o,               72'd0);
        chk("rst_win_valid", 72'(bus.win_valid_o),    72'd0);
        chk("rst_dv",        72'(bus.dv_o),           72'd0);
        chk("rst_col",       72'(bus.col_o),          72'd0);
        chk("rst_row",       72'(bus.row_o),          72'd0);
        chk("rst_ovf",       72'(bus.overflow_o),     72'd0);
        rst_n = 1;

        // Ramp frame, continuous dv, then with 3 idle cycles after each pixel
        ramp_frame(0);
        ramp_frame(3);

        // Overflow: two full-width lines, then a 20-pixel line
        n_valid = 0;
        vs_pulse();
        send_line(0, 16, 0, 1, 0);
        send_line(1, 16, 0, 1, 0);
        send_line(2, 20, 0, 1, 0);
        idle(3);
        chk("valid_count_ovf", 72'(n_valid), 72'd14);
        chk("ovf_sticky", 72'(bus.overflow_o), 72'd1);
        vs_pulse();
        idle(1);
        chk("ovf_cleared", 72'(bus.overflow_o), 72'd0);

        // Reset in the middle of row 2
        vs_pulse();
        send_line(0, 8, 0, 1, 0);
        send_line(1, 8, 0, 1, 0);
        for (int x = 0; x < 3; x++) tick(8'(32 + x), 1, 0, 0, 0, x, 2, x >= 2, 1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_win",   bus.win_o,            72'd0);
        chk("mid_rst_dv",    72'(bus.dv_o),        72'd0);
        chk("mid_rst_le",    72'(bus.line_end_o),  72'd0);
        chk("mid_rst_col",   72'(bus.col_o),       72'd0);
        chk("mid_rst_row",   72'(bus.row_o),       72'd0);
        chk("mid_rst_valid", 72'(bus.win_valid_o), 72'd0);
        bus.dv_i = 0; bus.y_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold_dv", 72'(bus.dv_o), 72'd0);
        rst_n = 1;
        clear_expect();
        n_valid = 0;
        send_line(0, 5, 0, 0, 0);
        send_line(1, 8, 0, 0, 0);
        send_line(2, 8, 0, 0, 0);
        idle(2);
        chk("valid_count_after_rst", 72'(n_valid), 72'd6);

        // Short lines never produce a window
        n_valid = 0;
        vs_pulse();
        for (int r = 0; r < 4; r++) send_line(r, 2, 0, 1, 0);
        idle(2);
        chk("valid_count_short", 72'(n_valid), 72'd0);

        // Frame start on the first pixel, then a 3-pixel third line
        n_valid = 0;
        send_line(0, 8, 0, 1, 1);
        send_line(1, 8, 0, 1, 0);
        send_line(2, 3, 0, 1, 0);
        idle(2);
        chk("valid_count_3px", 72'(n_valid), 72'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/y_window3x3.md
# y_window3x3

Streaming 3x3 neighbourhood generator that sits directly downstream of the RGB-to-luma stage in the HDMI processing chain. It consumes the 8-bit luma stream with its dv/hs/vs/line_end qualifiers and stores the two previous lines in on-chip line buffers. Each valid pixel produces a full 3x3 window of luma samples for the following filter stages (Sobel/edge, blur), with sync signals delayed to match.

## Interface
Parameters:
- MAX_WIDTH, 1024: maximum active pixels per line; sets line-buffer depth.
- COL_W, $clog2(MAX_WIDTH): column counter width.
- ROW_W, 11: row counter width.

Ports:
- clk  in  1  pixel clock; everything is single-clock.
- rst_n  in  1  asynchronous, active-low reset.
- y_i  in  8  luma sample.
- dv_i  in  1  data valid; y_i is meaningful only when high.
- hs_i  in  1  hsync, passed through.
- vs_i  in  1  vsync, active-high; its rising edge marks frame start.
- line_end_i  in  1  high together with the last dv_i pixel of a line.
- win_o  out  72  window; byte 3*r+c is win_o[8*(3*r+c)+:8]. r=0 is the oldest row (y-2), r=2 the current row. c=0 is the oldest column (x-2), c=2 the newest.
- win_valid_o  out  1  dv_o and all nine samples belong to the current frame's real pixels.
- dv_o, hs_o, vs_o, line_end_o  out  1 each  inputs delayed by 2 cycles.
- col_o  out  COL_W  column index x of win_o byte c=2 (newest column).
- row_o  out  ROW_W  row index y of win_o byte r=2 (current row).
- overflow_o  out  1  sticky; set when a line exceeds MAX_WIDTH; cleared at frame start.

## Operation
- Frame start: vs_i rising edge, detected against a registered copy of vs_i.
  - Frame start clears the column counter, row counter and overflow_o.
- Column counter col:
  - Increments on each dv_i pixel.
  - On a dv_i & line_end_i pixel, returns to 0 after that pixel.
  - Saturates at MAX_WIDTH-1.
- Row counter row:
  - Increments on each dv_i & line_end_i pixel.
  - Saturates at 2^ROW_W-1.
- Line buffer: one RAM, MAX_WIDTH x 16, read-before-write at address col.
  - Read returns {lb1,lb0}, where lb0 is row y-1 and lb1 is row y-2.
  - Write stores {lb0_read, y_i}.
  - Synchronous read, latency 1.
- Stage 0 (registered on dv_i):
  - Registers y_i, col and row.
  - Issues the RAM read and write.
- Stage 1: shifts the column {lb1, lb0, y_reg} into the c=2 position of three 3-deep shift registers; older columns move toward c=0.
- Shifting happens only on stage-1-valid cycles. When dv is low, the window holds its contents.
- win_valid_o = dv_o & (col_o >= 2) & (row_o >= 2).
- Overflow: a dv_i pixel with col already at MAX_WIDTH-1 and without line_end_i sets overflow_o.
  - On overflow, further pixels of that line are not written to the RAM.
  - The window still shifts but win_valid_o is forced low.
- The RAM is not reset. Stale contents are masked by the row >= 2 gate.
- A line shorter than the previous one leaves stale data beyond its length. That data is never read as valid, because col restarts at 0.
- Lines of fewer than 3 pixels never assert win_valid_o.

## Timing
- Latency: y_i at cycle t appears in win_o byte 8 (r=2, c=2) at cycle t+2, together with dv_o, col_o and row_o.
- hs_o, vs_o and line_end_o use the same 2-cycle delay. line_end_o stays coincident with the last dv_o pixel.
- Reset values (asynchronous, while rst_n=0): win_o, win_valid_o, dv_o, hs_o, vs_o, line_end_o, col_o, row_o and overflow_o are all 0; counters and shift registers are 0.
- Reset mid-frame: outputs go to 0 immediately. After release, counting starts at row 0, col 0 with the next pixel, so no valid window appears for the first two lines.
- If frame start and a dv_i pixel occur in the same cycle, that pixel is col 0, row 0 of the new frame.
- If line_end_i arrives without dv_i, it is ignored.
- Throughput: one pixel per clock. Back-to-back dv_i is supported with no stalls.

## Test plan
- Ramp frame: 8x4 pixels with y = 16*row + col and continuous dv.
  - At input pixel (4,2): win_o rows are {2,3,4}, {18,19,20}, {34,35,36}.
  - win_valid_o is high for exactly 6x2 = 12 cycles per frame.
- Latency check: a single-pixel change in y_i at cycle t is visible at win_o[71:64] at t+2. dv_o, hs_o, vs_o and line_end_o are aligned to the same cycle.
- Gapped dv: insert 3 idle cycles between every pixel.
  - The window holds during gaps.
  - Contents match the continuous-dv ramp test for every valid window.
- Overflow: MAX_WIDTH=16, send a 20-pixel line.
  - overflow_o rises on pixel 16 and stays high.
  - win_valid_o is low for pixels 16-19.
  - The next vs_i rising edge clears overflow_o.
- Reset mid-frame: drop rst_n during row 2 of the ramp frame.
  - All outputs are 0 within the reset.
  - After release, win_valid_o stays low until the third line of input.
- Short lines: lines of 2 pixels never assert win_valid_o. A 3-pixel line after two 8-pixel lines gives exactly 1 valid window.
